// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM state type and op decode helper for alu_mdu
package alu_pkg;

   localparam logic [4:0] OP_ADD    = 5'h00;
   localparam logic [4:0] OP_SUB    = 5'h01;
   localparam logic [4:0] OP_AND    = 5'h02;
   localparam logic [4:0] OP_OR     = 5'h03;
   localparam logic [4:0] OP_SLL    = 5'h04;
   localparam logic [4:0] OP_SRL    = 5'h05;
   localparam logic [4:0] OP_XOR    = 5'h06;
   localparam logic [4:0] OP_SLT    = 5'h07;
   localparam logic [4:0] OP_SLTU   = 5'h08;
   localparam logic [4:0] OP_SRA    = 5'h0A;
   localparam logic [4:0] OP_MUL    = 5'h10;
   localparam logic [4:0] OP_MULH   = 5'h11;
   localparam logic [4:0] OP_MULHSU = 5'h12;
   localparam logic [4:0] OP_MULHU  = 5'h13;
   localparam logic [4:0] OP_DIV    = 5'h14;
   localparam logic [4:0] OP_DIVU   = 5'h15;
   localparam logic [4:0] OP_REM    = 5'h16;
   localparam logic [4:0] OP_REMU   = 5'h17;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_FIX,
      ST_DONE
   } state_e;

   // True only for the eight ops that run on the iterative datapath;
   // 0x18-0x1F complete like base ops with a zero result.
   function automatic logic is_mop(input logic [4:0] op);
      return op[4:3] == 2'b10;
   endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// rtl/alu_mdu_if.sv - request/response handshake bundle between EX stage and alu_mdu
interface alu_mdu_if #(
   parameter int XLEN = 32
) ();
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output in_valid, op, a, b, kill, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, op, a, b, kill, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - radix-2 iterative multiply/divide on operand magnitudes with sign fix-up
module mdu_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] res
);
   localparam int SHW = $clog2(XLEN);

   logic            run_q, run_d;
   logic [SHW-1:0]  cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d;
   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;

   logic            sa_in, sa, sb;
   logic [XLEN:0]   sum, shl, diff;
   logic [2*XLEN-1:0] prod, prod_n;
   logic [XLEN-1:0] quo_n, rem_n;

   // Signed-operand decode: a is signed for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM.
   assign sa_in = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6) && a[XLEN-1];
   assign sa    = (op_q == 3'd1 || op_q == 3'd2 || op_q == 3'd4 || op_q == 3'd6) && a_q[XLEN-1];
   assign sb    = (op_q == 3'd1 || op_q == 3'd4 || op_q == 3'd6) && b_q[XLEN-1];

   // done marks the cycle of the final step, so the result is ready one cycle later.
   assign done = run_q && (cnt_q == SHW'(XLEN - 1));

   assign sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? dvs_q : {XLEN{1'b0}})};
   assign shl  = {hi_q, lo_q[XLEN-1]};
   assign diff = shl - {1'b0, dvs_q};

   always_comb begin
      run_d = run_q;
      cnt_d = cnt_q;
      op_d  = op_q;
      a_d   = a_q;
      b_d   = b_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      dvs_d = dvs_q;
      if (start) begin
         run_d = 1'b1;
         cnt_d = '0;
         op_d  = op;
         a_d   = a;
         b_d   = b;
         hi_d  = '0;
         lo_d  = sa_in ? -a : a;
         dvs_d = ((op == 3'd1 || op == 3'd4 || op == 3'd6) && b[XLEN-1]) ? -b : b;
      end else if (kill) begin
         run_d = 1'b0;
      end else if (run_q) begin
         cnt_d = cnt_q + 1'b1;
         if (done) run_d = 1'b0;
         if (!op_q[2]) begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
         end else if (!diff[XLEN]) begin
            hi_d = diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_d = shl[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
         end
      end
   end

   assign prod   = {hi_q, lo_q};
   assign prod_n = (sa ^ sb) ? -prod : prod;
   assign quo_n  = (sa ^ sb) ? -lo_q : lo_q;
   assign rem_n  = sa ? -hi_q : hi_q;

   always_comb begin
      res = '0;
      case (op_q)
         3'd0:                res = prod_n[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    res = prod_n[2*XLEN-1:XLEN];
         3'd4, 3'd5:          res = (b_q == '0) ? {XLEN{1'b1}} : quo_n;
         default:             res = (b_q == '0) ? a_q : rem_n;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         dvs_q <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         op_q  <= op_d;
         a_q   <= a_d;
         b_q   <= b_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         dvs_q <= dvs_d;
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - EX-stage ALU with iterative M extension, registered result and valid/ready handshake
module alu_mdu
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_mdu_if.slave  bus
);
   localparam int SHW = $clog2(XLEN);

   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] base_res;
   logic [SHW-1:0]  shamt;
   logic            fire, mdu_start, mdu_done;
   logic [XLEN-1:0] mdu_res;

   assign bus.in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && bus.out_ready);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q == ST_BUSY) || (state_q == ST_FIX);
   assign bus.result    = result_q;

   // A request arriving together with kill is dropped.
   assign fire  = bus.in_valid && bus.in_ready && !bus.kill;
   assign shamt = bus.b[SHW-1:0];

   always_comb begin
      base_res = '0;
      case (bus.op)
         OP_ADD:  base_res = bus.a + bus.b;
         OP_SUB:  base_res = bus.a - bus.b;
         OP_AND:  base_res = bus.a & bus.b;
         OP_OR:   base_res = bus.a | bus.b;
         OP_SLL:  base_res = bus.a << shamt;
         OP_SRL:  base_res = bus.a >> shamt;
         OP_XOR:  base_res = bus.a ^ bus.b;
         OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
         OP_SLTU: base_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
         OP_SRA:  base_res = $signed(bus.a) >>> shamt;
         default: base_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      mdu_start = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (fire) begin
               if (is_mop(bus.op)) begin
                  state_d   = ST_BUSY;
                  mdu_start = 1'b1;
               end else begin
                  state_d  = ST_DONE;
                  result_d = base_res;
               end
            end else if (state_q == ST_DONE && bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: if (mdu_done) state_d = ST_FIX;
         ST_FIX: begin
            result_d = mdu_res;
            state_d  = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (bus.kill) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
      end
   end

   mdu_iter #(.XLEN(XLEN)) u_mdu (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mdu_start),
      .kill  (bus.kill),
      .op    (bus.op[2:0]),
      .a     (bus.a),
      .b     (bus.b),
      .done  (mdu_done),
      .res   (mdu_res)
   );

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle integer ALU. Width is XLEN, and the output is registered.
- Adds the RV32M/RV64M multiply/divide/remainder operations, computed iteratively over multiple cycles.
- Sits in the EX stage. Uses a valid/ready handshake so the pipeline stalls while a multi-cycle op runs.
- Accepts a kill input so a branch or trap flush can abort an in-flight op.

Parameters:
- XLEN, 32: operand/result width. Legal values are 32 and 64.
- SHW, $clog2(XLEN): shift-amount bits. Derived; not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept the request this cycle.
- op  in  5  operation code (see Behaviour).
- a  in  XLEN  operand 1 (rs1 or pc).
- b  in  XLEN  operand 2 (rs2 or imm).
- kill  in  1  synchronous abort of the in-flight or pending op.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  registered result.
- busy  out  1  high in BUSY or FIX.

Behaviour:
- Base op codes (op[4]=0):
  - 0x0 ADD, 0x1 SUB (both modulo 2^XLEN, wrap silently).
  - 0x2 AND, 0x3 OR, 0x4 SLL, 0x5 SRL, 0x6 XOR.
  - 0x7 SLT (signed), 0x8 SLTU, 0xA SRA.
  - 0x9 and 0xB-0xF produce result 0.
- M op codes (op[4]=1):
  - 0x10 MUL, 0x11 MULH, 0x12 MULHSU, 0x13 MULHU.
  - 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU.
  - 0x18-0x1F produce result 0 with base-op latency.
- All shifts use b[SHW-1:0] only; upper bits of b are ignored.
- A handshake fires when in_valid && in_ready. Operands and op are captured on that edge and may change afterwards.
- FSM states: IDLE, BUSY, FIX, DONE.
  - IDLE: in_ready=1. On a fire with a base op, go to DONE and load result on the same edge (out_valid rises 1 cycle after accept). On a fire with an M op, go to BUSY with count=0.
  - BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide on operand magnitudes). After XLEN steps, go to FIX.
  - FIX: apply sign correction and special cases, load result, go to DONE. out_valid rises exactly XLEN+2 cycles after accept.
  - DONE: out_valid=1, and result is held stable until out_ready.
    - On out_ready with a new fire in the same cycle: take the new request (back-to-back; base ops reach 1 per cycle).
    - On out_ready with no fire: go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Special cases:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return a.
  - Signed overflow (a = most-negative, b = -1): DIV returns a; REM returns 0.
  - Special cases still take the full XLEN+2 latency.
- MULH/MULHSU/MULHU return the upper XLEN bits of the 2*XLEN product; MUL returns the lower XLEN bits.
- kill:
  - In any state, next state is IDLE, out_valid drops on the next edge, and the result is discarded.
  - A fire coincident with kill is ignored.
  - kill has priority over out_ready.
- Reset (asynchronous, any state, including mid-BUSY):
  - state=IDLE, out_valid=0, result=0, busy=0, count=0, internal accumulators=0.
  - in_ready=1 once reset is released.

Decomposition:
- Package alu_pkg holds:
  - localparams for all op codes;
  - FSM state enum;
  - helper function is_mop(op).
- One sub-module, mdu_iter, holds the iterative multiply/divide datapath, count, and sign/special-case fix.
  - Interface: start, op[2:0], a, b, done, res.
- alu_mdu holds the base-op logic, FSM, and handshake.

Test Plan:
- ADD a=0x7FFFFFFF b=1 with out_ready=1 held -> result 0x80000000, out_valid 1 cycle after accept. Then back-to-back SRA a=0x80000000 b=0x24 (shift 4) -> 0xF8000000 on the next cycle.
- DIVU a=100 b=7 -> 14 at exactly 34 cycles after accept. REMU with the same operands -> 2. busy=1 for the intervening cycles and in_ready=0.
- MULH a=b=0x80000000 -> 0x40000000. MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF. MUL a=0xFFFFFFFF b=0xFFFFFFFF -> 0x00000001.
- DIV 7/0 -> 0xFFFFFFFF. REM 7/0 -> 7. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- DIV issued, kill pulsed at cycle 10 -> no out_valid, IDLE next cycle. Then ADD 2+3 with out_ready=0 for 5 cycles -> result 5 held, in_ready=0 throughout.
- rst_n asserted asynchronously mid-BUSY (between clock edges) -> out_valid=0, result=0, busy=0 immediately. After release, a new SUB 3-5 -> 0xFFFFFFFE.
